// File: rtl/rv_iopmp_entry_walker.sv
// Sequential IOPMP entry checker: walks entries start..end one per cycle
// through a single shared TOR/NA4/NAPOT matcher and reports the first hit.
// Optional performance counters are built when RV_IOPMP_WALKER_PERF_EN is defined.
module rv_iopmp_entry_walker #(
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int LEN         = 32,
    localparam int IW  = $clog2(NUM_ENTRIES),
    localparam int NBW = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NBW-1:0]        req_num_bytes_i,
    input  logic [IW-1:0]         req_start_idx_i,
    input  logic [IW-1:0]         req_end_idx_i,
    output logic [IW-1:0]         entry_idx_o,
    input  logic [LEN-1:0]        entry_addr_i,
    input  logic [LEN-1:0]        entry_addrh_i,
    input  logic [1:0]            entry_mode_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [IW-1:0]         rsp_idx_o,
    output logic                  rsp_allow_o,
    output logic                  busy_o
`ifdef RV_IOPMP_WALKER_PERF_EN
    ,
    input  logic                  perf_clr_i,
    output logic [31:0]           perf_walk_cycles_o,
    output logic [31:0]           perf_miss_cnt_o
`endif
);

    localparam int EW = 2 * LEN;
    // Compare width holds both the entry byte address and a+n-1 without overflow.
    localparam int CW = (ADDR_WIDTH + 1 > EW + 3) ? ADDR_WIDTH + 1 : EW + 3;

    typedef enum logic [1:0] {IDLE, PREV, WALK, RESP} state_t;
    typedef enum logic [1:0] {MODE_OFF, MODE_TOR, MODE_NA4, MODE_NAPOT} mode_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NBW-1:0]        nb_q, nb_d;
    logic [IW-1:0]         start_q, start_d, end_q, end_d;
    logic [IW-1:0]         idx_q, idx_d, ridx_q, ridx_d;
    logic [EW-1:0]         prev_q, prev_d;
    logic                  hit_q, hit_d, allow_q, allow_d;

    logic [EW-1:0]         e_addr;
    logic [CW-1:0]         a_ext, last_ext, e_byte, prev_byte, mask, base, top;
    int unsigned           ones, size;
    logic                  run, match, allow;

    assign e_addr = {entry_addrh_i, entry_addr_i};

    // Shared address matcher for the entry currently on the read port.
    always_comb begin
        a_ext     = CW'(addr_q);
        last_ext  = a_ext + CW'(nb_q) - CW'(1);
        e_byte    = CW'(e_addr) << 2;
        prev_byte = CW'(prev_q) << 2;
        ones      = 0;
        run       = 1'b1;
        for (int unsigned i = 0; i < EW; i++) begin
            if (run && e_addr[i]) ones = ones + 1;
            else                  run  = 1'b0;
        end
        size = (mode_t'(entry_mode_i) == MODE_NA4) ? 2 : ones + 3;
        for (int unsigned i = 0; i < CW; i++) mask[i] = (i >= size);
        // base is size-aligned, so base | ~mask is the region's last byte.
        base  = e_byte & mask;
        top   = base | ~mask;
        match = 1'b0;
        allow = 1'b0;
        case (mode_t'(entry_mode_i))
            MODE_TOR: begin
                match = (prev_byte <= a_ext) && (a_ext < e_byte);
                allow = last_ext < e_byte;
            end
            MODE_NA4, MODE_NAPOT: begin
                match = (a_ext & mask) == base;
                allow = last_ext <= top;
            end
            default: ;
        endcase
    end

    // Next-state and datapath update for the walk FSM.
    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        nb_d    = nb_q;
        start_d = start_q;
        end_d   = end_q;
        idx_d   = idx_q;
        ridx_d  = ridx_q;
        prev_d  = prev_q;
        hit_d   = hit_q;
        allow_d = allow_q;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    nb_d    = req_num_bytes_i;
                    start_d = req_start_idx_i;
                    end_d   = req_end_idx_i;
                    if (req_start_idx_i > req_end_idx_i) begin
                        hit_d   = 1'b0;
                        allow_d = 1'b0;
                        state_d = RESP;
                    end else if (req_start_idx_i == '0) begin
                        prev_d  = '0;
                        idx_d   = '0;
                        state_d = WALK;
                    end else begin
                        idx_d   = req_start_idx_i - IW'(1);
                        state_d = PREV;
                    end
                end
            end
            PREV: begin
                prev_d  = e_addr;
                idx_d   = start_q;
                state_d = WALK;
            end
            WALK: begin
                if (match) begin
                    hit_d   = 1'b1;
                    ridx_d  = idx_q;
                    allow_d = allow;
                    state_d = RESP;
                end else begin
                    prev_d = e_addr;
                    if (idx_q == end_q) begin
                        hit_d   = 1'b0;
                        allow_d = 1'b0;
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            addr_q  <= '0;
            nb_q    <= '0;
            start_q <= '0;
            end_q   <= '0;
            idx_q   <= '0;
            ridx_q  <= '0;
            prev_q  <= '0;
            hit_q   <= 1'b0;
            allow_q <= 1'b0;
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            nb_q    <= nb_d;
            start_q <= start_d;
            end_q   <= end_d;
            idx_q   <= idx_d;
            ridx_q  <= ridx_d;
            prev_q  <= prev_d;
            hit_q   <= hit_d;
            allow_q <= allow_d;
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign busy_o      = (state == PREV) || (state == WALK);
    assign entry_idx_o = idx_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_idx_o   = ridx_q;
    assign rsp_allow_o = allow_q;

`ifdef RV_IOPMP_WALKER_PERF_EN
    // Saturating walk-cycle and miss counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_walk_cycles_o <= '0;
            perf_miss_cnt_o    <= '0;
        end else if (perf_clr_i) begin
            perf_walk_cycles_o <= '0;
            perf_miss_cnt_o    <= '0;
        end else begin
            if (busy_o && perf_walk_cycles_o != '1)
                perf_walk_cycles_o <= perf_walk_cycles_o + 32'd1;
            if (state != RESP && state_d == RESP && !hit_d && perf_miss_cnt_o != '1)
                perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule
